// File: rtl/oled_frame_scheduler.sv
// Frame-aligned owner arbitration of the 96x64 OLED pixel stream between N scene sources.
// Optional macro OLED_SCHED_BLANK_EN inserts one black frame on every owner-to-owner handover.
module oled_frame_scheduler #(
    parameter int unsigned N           = 4,
    parameter int unsigned HOLD_FRAMES = 8,
    parameter logic [15:0] BG_COLOUR   = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_begin,
    input  logic              sample_pixel,
    input  logic [12:0]       pixel_index,
    input  logic [N-1:0]      req,
    input  logic [16*N-1:0]   src_colour,
    output logic [N-1:0]      grant,
    output logic [6:0]        x,
    output logic [5:0]        y,
    output logic [15:0]       frame_cnt,
    output logic              switch_pulse,
    output logic              sync_err,
    output logic [15:0]       oled_colour
);

    localparam int unsigned   IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [7:0]    HOLD_LIM = 8'(HOLD_FRAMES - 1);
    localparam logic [IW-1:0] LAST_RST = IW'(N - 1);

`ifdef OLED_SCHED_BLANK_EN
    typedef enum logic [1:0] {IDLE, OWN, BLANK} state_t;
`else
    typedef enum logic [1:0] {IDLE, OWN} state_t;
`endif

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] last_owner_q, last_owner_d;
    logic [7:0]    hold_cnt_q, hold_cnt_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [N-1:0]  grant_dly_q;
    logic          switch_pulse_q, switch_pulse_d;
    logic [6:0]    x_q, x_d;
    logic [5:0]    y_q, y_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          sync_err_q, sync_err_d;

    logic          rr_found;
    logic [IW-1:0] rr_pick;
    logic [IW-1:0] cand;
    logic          take;
    logic [12:0]   pos_expect;

    // Round-robin search upward from last_owner+1; the current owner is skipped while it holds
    // the display so that "another request pending" never selects the owner itself.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        cand     = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IW'((32'(last_owner_q) + i) % N);
            if (!rr_found && req[cand] && !(state_q == OWN && cand == owner_q)) begin
                rr_found = 1'b1;
                rr_pick  = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;
        take         = 1'b0;
        if (frame_begin) begin
            case (state_q)
                IDLE: take = rr_found;
                OWN: begin
                    if (!req[owner_q]) begin
                        take = rr_found;
                        if (!rr_found) state_d = IDLE;
                    end else if (hold_cnt_q >= HOLD_LIM && rr_found) begin
                        take = 1'b1;
                    end else if (hold_cnt_q != 8'hFF) begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end
`ifdef OLED_SCHED_BLANK_EN
                BLANK: begin
                    take = rr_found;
                    if (!rr_found) state_d = IDLE;
                end
`endif
                default: state_d = IDLE;
            endcase

            if (take) begin
                hold_cnt_d = '0;
`ifdef OLED_SCHED_BLANK_EN
                // Owner-to-owner handover parks in BLANK; the winner is re-arbitrated next frame.
                if (state_q == OWN) begin
                    state_d = BLANK;
                end else begin
                    state_d      = OWN;
                    owner_d      = rr_pick;
                    last_owner_d = rr_pick;
                end
`else
                state_d      = OWN;
                owner_d      = rr_pick;
                last_owner_d = rr_pick;
`endif
            end
        end

        grant_d = '0;
        if (state_d == OWN) grant_d[owner_d] = 1'b1;
        switch_pulse_d = (grant_q != grant_dly_q);
    end

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        frame_cnt_d = frame_cnt_q;
        sync_err_d  = sync_err_q;
        pos_expect  = {7'd0, y_q} * 13'd96 + {6'd0, x_q};
        if (frame_begin) begin
            x_d         = '0;
            y_d         = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else if (sample_pixel) begin
            if (pixel_index != pos_expect) sync_err_d = 1'b1;
            if (x_q == 7'd95) begin
                x_d = '0;
                y_d = (y_q == 6'd63) ? 6'd0 : y_q + 6'd1;
            end else begin
                x_d = x_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            owner_q        <= '0;
            last_owner_q   <= LAST_RST;
            hold_cnt_q     <= '0;
            grant_q        <= '0;
            grant_dly_q    <= '0;
            switch_pulse_q <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
            frame_cnt_q    <= '0;
            sync_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_owner_q   <= last_owner_d;
            hold_cnt_q     <= hold_cnt_d;
            grant_q        <= grant_d;
            grant_dly_q    <= grant_q;
            switch_pulse_q <= switch_pulse_d;
            x_q            <= x_d;
            y_q            <= y_d;
            frame_cnt_q    <= frame_cnt_d;
            sync_err_q     <= sync_err_d;
        end
    end

    always_comb begin
        oled_colour = BG_COLOUR;
        case (state_q)
            OWN: oled_colour = src_colour[{owner_q, 4'b0000} +: 16];
`ifdef OLED_SCHED_BLANK_EN
            BLANK: oled_colour = '0;
`endif
            default: oled_colour = BG_COLOUR;
        endcase
    end

    assign grant        = grant_q;
    assign x            = x_q;
    assign y            = y_q;
    assign frame_cnt    = frame_cnt_q;
    assign switch_pulse = switch_pulse_q;
    assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_oled_frame_scheduler.sv
// Bench for oled_frame_scheduler: frame-level reference model checked every cycle plus directed literals.
// Follows OLED_SCHED_BLANK_EN the same way the design does.
module tb_oled_frame_scheduler;

    localparam int          N    = 4;
    localparam int          HOLD = 8;
    localparam logic [15:0] BG   = 16'h1234;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_begin = 1'b0;
    logic        sample_pixel = 1'b0;
    logic [12:0] pixel_index = '0;
    logic [3:0]  req = '0;
    logic [63:0] src_colour = {16'h000D, 16'h00C0, 16'h0B00, 16'hA000};
    logic [3:0]  grant;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [15:0] frame_cnt;
    logic        switch_pulse;
    logic        sync_err;
    logic [15:0] oled_colour;

    int checks   = 0;
    int failures = 0;

    oled_frame_scheduler #(.N(N), .HOLD_FRAMES(HOLD), .BG_COLOUR(BG)) dut (
        .clk(clk), .reset(reset), .frame_begin(frame_begin), .sample_pixel(sample_pixel),
        .pixel_index(pixel_index), .req(req), .src_colour(src_colour), .grant(grant),
        .x(x), .y(y), .frame_cnt(frame_cnt), .switch_pulse(switch_pulse),
        .sync_err(sync_err), .oled_colour(oled_colour)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = no owner, 1 = owned, 2 = blank frame; position kept as a linear pixel number.
    int         m_mode, m_owner, m_hold, m_last, m_pos, m_fcnt;
    bit         m_err, m_sw;
    logic [3:0] m_g, m_g1;

    function automatic int rr(input logic [3:0] r, input int last, input int excl);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (c != excl && r[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_grant();
        logic [3:0] g;
        g = '0;
        if (m_mode == 1) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic logic [15:0] exp_colour();
        if (m_mode == 1) return src_colour[16*m_owner +: 16];
        if (m_mode == 2) return 16'h0000;
        return BG;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_owner = 0; m_hold = 0; m_last = N - 1;
        m_pos = 0; m_fcnt = 0; m_err = 0; m_sw = 0; m_g = '0; m_g1 = '0;
    endtask

    task automatic give(input int p);
        m_mode = 1; m_owner = p; m_last = p; m_hold = 0;
    endtask

    task automatic model_step();
        int p;
        m_sw = (m_g != m_g1);
        m_g1 = m_g;
        if (frame_begin) begin
            m_fcnt = (m_fcnt + 1) % 65536;
            m_pos  = 0;
            if (m_mode == 0) begin
                p = rr(req, m_last, -1);
                if (p >= 0) give(p);
            end else if (m_mode == 1) begin
                p = rr(req, m_last, m_owner);
                if (!req[m_owner] || (m_hold >= HOLD - 1 && p >= 0)) begin
                    if (p < 0) m_mode = 0;
                    else begin
`ifdef OLED_SCHED_BLANK_EN
                        m_mode = 2; m_hold = 0;
`else
                        give(p);
`endif
                    end
                end else begin
                    m_hold = (m_hold < 255) ? m_hold + 1 : 255;
                end
            end else begin
                p = rr(req, m_last, -1);
                if (p >= 0) give(p);
                else m_mode = 0;
            end
        end else if (sample_pixel) begin
            if (int'(pixel_index) != m_pos) m_err = 1;
            m_pos = (m_pos + 1) % 6144;
        end
        m_g = exp_grant();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_grant",  32'(grant),        32'(exp_grant()));
            chk("cyc_x",      32'(x),            32'(m_pos % 96));
            chk("cyc_y",      32'(y),            32'(m_pos / 96));
            chk("cyc_fcnt",   32'(frame_cnt),    32'(m_fcnt));
            chk("cyc_switch", 32'(switch_pulse), 32'(m_sw));
            chk("cyc_syncer", 32'(sync_err),     32'(m_err));
            chk("cyc_colour", 32'(oled_colour),  32'(exp_colour()));
        end
    end

    // Called at posedge+2; applies inputs across exactly one rising edge.
    task automatic step(input logic fb, input logic sp, input logic [12:0] idx);
        frame_begin = fb; sample_pixel = sp; pixel_index = idx;
        @(posedge clk); #2;
        frame_begin = 1'b0; sample_pixel = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_grant",  32'(grant), 32'h0);
        chk("rst_xy",     32'({x, y}), 32'h0);
        chk("rst_fcnt",   32'(frame_cnt), 32'h0);
        chk("rst_colour", 32'(oled_colour), 32'(BG));
        reset = 1'b0;
        step(1'b0, 1'b0, 13'd0);

        // Single requester from idle.
        req = 4'b0100;
        step(1'b1, 1'b0, 13'd0);
        chk("first_grant",  32'(grant), 32'h4);
        chk("first_colour", 32'(oled_colour), 32'h00C0);
        chk("first_sw0",    32'(switch_pulse), 32'h0);
        chk("first_fcnt",   32'(frame_cnt), 32'h1);
        step(1'b0, 1'b0, 13'd0);
        chk("first_sw1",    32'(switch_pulse), 32'h1);
        step(1'b0, 1'b0, 13'd0);
        chk("first_sw2",    32'(switch_pulse), 32'h0);
        src_colour[47:32] = 16'h5A5A;
        #1;
        chk("colour_follow", 32'(oled_colour), 32'h5A5A);
        src_colour[47:32] = 16'h00C0;

        // Owner drops mid-frame: grant holds until the boundary.
        req = 4'b0000;
        repeat (3) step(1'b0, 1'b0, 13'd0);
        chk("drop_hold", 32'(grant), 32'h4);
        step(1'b1, 1'b0, 13'd0);
        chk("drop_idle",   32'(grant), 32'h0);
        chk("drop_colour", 32'(oled_colour), 32'(BG));
        chk("drop_fcnt",   32'(frame_cnt), 32'h2);
        repeat (2) step(1'b0, 1'b0, 13'd0);

        // Two requesters sharing under the hold rule.
        req = 4'b0011;
        for (int f = 1; f <= 20; f++) begin
            step(1'b1, 1'b0, 13'd0);
`ifdef OLED_SCHED_BLANK_EN
            if (f == 1)  chk("rot_f1",  32'(grant), 32'h1);
            if (f == 9)  chk("rot_f9",  32'(grant), 32'h0);
            if (f == 9)  chk("rot_blank_colour", 32'(oled_colour), 32'h0);
            if (f == 10) chk("rot_f10", 32'(grant), 32'h2);
            if (f == 18) chk("rot_f18", 32'(grant), 32'h0);
            if (f == 19) chk("rot_f19", 32'(grant), 32'h1);
`else
            if (f == 1)  chk("rot_f1",  32'(grant), 32'h1);
            if (f == 8)  chk("rot_f8",  32'(grant), 32'h1);
            if (f == 9)  chk("rot_f9",  32'(grant), 32'h2);
            if (f == 16) chk("rot_f16", 32'(grant), 32'h2);
            if (f == 17) chk("rot_f17", 32'(grant), 32'h1);
`endif
            repeat (2) step(1'b0, 1'b0, 13'd0);
        end
        req = 4'b0000;
        step(1'b1, 1'b0, 13'd0);
        chk("rel_idle", 32'(grant), 32'h0);
        chk("rel_fcnt", 32'(frame_cnt), 32'd23);

        // Full frame of samples with correct indices.
        step(1'b1, 1'b0, 13'd0);
        for (int i = 0; i < 6144; i++) begin
            step(1'b0, 1'b1, 13'(i));
            if (i == 96)   chk("pos_97",   32'({x, y}), 32'({7'd1, 6'd1}));
            if (i == 6142) chk("pos_last", 32'({x, y}), 32'({7'd95, 6'd63}));
        end
        chk("pos_wrap",    32'({x, y}), 32'h0);
        chk("pos_syncerr", 32'(sync_err), 32'h0);

        // frame_begin wins over a coincident sample (bad index ignored).
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 13'(i));
        chk("pre_coinc_x", 32'(x), 32'd5);
        step(1'b1, 1'b1, 13'd999);
        chk("coinc_xy",   32'({x, y}), 32'h0);
        chk("coinc_fcnt", 32'(frame_cnt), 32'd25);
        chk("coinc_err",  32'(sync_err), 32'h0);

        // Index mismatch at count 99 is sticky.
        for (int i = 0; i < 99; i++) step(1'b0, 1'b1, 13'(i));
        chk("err_before", 32'(sync_err), 32'h0);
        step(1'b0, 1'b1, 13'd100);
        chk("err_set", 32'(sync_err), 32'h1);
        step(1'b1, 1'b0, 13'd0);
        chk("err_sticky", 32'(sync_err), 32'h1);

        // Long single ownership saturates the hold count; a newcomer still preempts.
        req = 4'b0001;
        for (int f = 0; f < 260; f++) begin
            step(1'b1, 1'b0, 13'd0);
            step(1'b0, 1'b0, 13'd0);
        end
        chk("sat_owner", 32'(grant), 32'h1);
        req = 4'b0011;
        step(1'b1, 1'b0, 13'd0);
`ifdef OLED_SCHED_BLANK_EN
        chk("sat_preempt", 32'(grant), 32'h0);
`else
        chk("sat_preempt", 32'(grant), 32'h2);
`endif

        // Asynchronous reset mid-frame.
        repeat (3) step(1'b0, 1'b1, 13'd0);
        reset = 1'b1;
        #1;
        chk("arst_grant",  32'(grant), 32'h0);
        chk("arst_xy",     32'({x, y}), 32'h0);
        chk("arst_fcnt",   32'(frame_cnt), 32'h0);
        chk("arst_err",    32'(sync_err), 32'h0);
        chk("arst_colour", 32'(oled_colour), 32'(BG));
        step(1'b1, 1'b0, 13'd0);
        reset = 1'b0;
        step(1'b0, 1'b0, 13'd0);
        chk("post_rst_idle", 32'(grant), 32'h0);
        step(1'b1, 1'b0, 13'd0);
        chk("post_rst_grant", 32'(grant), 32'h1);
        repeat (3) step(1'b0, 1'b0, 13'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oled_frame_scheduler.md
# oled_frame_scheduler

Owns the 96x64 OLED pixel stream and shares it between up to N scene sources (menu, fight arena, HUD overlay, win screen). Sits between the scene renderers and the OLED driver in the 6.25 MHz domain. Consumes the driver's `frame_begin` / `sample_pixel` / `pixel_index` and returns `oled_colour`. Ownership changes only on frame boundaries, so no frame ever mixes two sources.

## Interface
- `N`, 4: number of requesters, 1..8.
- `HOLD_FRAMES`, 8: minimum frames an owner keeps the display before a waiting requester can preempt it; 1..255.
- `BG_COLOUR`, 16'h0000: RGB565 colour driven when no source owns the display.
- `clk`  in  1  OLED pixel clock, 6.25 MHz.
- `reset`  in  1  asynchronous, active-high.
- `frame_begin`  in  1  one-cycle pulse from the OLED driver at the start of each frame.
- `sample_pixel`  in  1  one-cycle pulse; the driver latches `oled_colour` for the current `pixel_index`.
- `pixel_index`  in  13  driver pixel index, 0..6143.
- `req`  in  N  level request per source; bit i set means source i wants the display.
- `src_colour`  in  16*N  RGB565 per source; slice [16i+15:16i] belongs to source i.
- `grant`  out  N  one-hot owner, or all zero when idle; registered.
- `x`  out  7  current column 0..95; registered.
- `y`  out  6  current row 0..63; registered.
- `frame_cnt`  out  16  frames since reset; wraps.
- `switch_pulse`  out  1  one-cycle pulse in the cycle after `grant` changes.
- `sync_err`  out  1  sticky; set on position counter mismatch.
- `oled_colour`  out  16  pixel to the driver.

## Operation
- States:
  - IDLE: no owner.
  - OWN: one owner.
  - BLANK: present only with the macro; see Configuration.
- FSM transitions are evaluated only in cycles where `frame_begin` = 1.
- IDLE:
  - If any `req` bit is set, grant by round-robin, searching upward from `last_owner + 1` modulo N.
  - Go to OWN and clear `hold_cnt`.
- OWN, owner's `req` low: release.
  - If another request is pending, grant the next one round-robin and stay in OWN.
  - Otherwise go to IDLE.
- OWN, owner's `req` high:
  - If `hold_cnt` ≥ HOLD_FRAMES-1 and another request is pending, rotate to the next requester round-robin.
  - Otherwise keep the owner and increment `hold_cnt`, saturating at 255.
- `last_owner` is updated on every grant. Its reset value is N-1, so source 0 wins the first arbitration.
- `oled_colour` is the owner's `src_colour` slice. It is `BG_COLOUR` in IDLE, and 16'h0000 in BLANK.
- The `oled_colour` mux is combinational from the registered grant index.
- Position counters:
  - `frame_begin` sets x = 0 and y = 0.
  - `sample_pixel` advances x. When x = 95, x wraps to 0 and y increments.
  - When y = 63 and x = 95, both wrap to 0.
- On every `sample_pixel`, compare `pixel_index` against y*96 + x (pre-increment values). If they differ, set `sync_err`. Only reset clears it.
- `frame_cnt` increments on every `frame_begin` and wraps from 16'hFFFF to 0.

## Timing
- Reset values:
  - `grant` = 0, state = IDLE, `hold_cnt` = 0, `last_owner` = N-1.
  - `x` = 0, `y` = 0, `frame_cnt` = 0.
  - `switch_pulse` = 0, `sync_err` = 0.
  - `oled_colour` = `BG_COLOUR`.
- `grant` changes in the cycle after the `frame_begin` edge; `switch_pulse` is high in the following cycle.
- `oled_colour` follows `src_colour` combinationally, with zero latency to `sample_pixel`.
- `frame_begin` and `sample_pixel` asserted in the same cycle: `frame_begin` wins. The sample is ignored for counters and the mismatch check.
- `req` changes between frame boundaries have no effect until the next `frame_begin`.
- Reset asserted mid-frame forces all reset values immediately. The first frame after release starts at the next `frame_begin`.

## Configuration
- `OLED_SCHED_BLANK_EN` defined:
  - Any change from one owner to a different owner inserts exactly one BLANK frame.
  - At the switching `frame_begin`, go to BLANK and drive 16'h0000.
  - At the next `frame_begin`, go to OWN with the pending winner. The winner is re-arbitrated at that boundary.
  - If no requests remain at that boundary, go to IDLE.
  - `grant` = 0 during BLANK.
  - IDLE→OWN and OWN→IDLE transitions are not blanked.
- Undefined: the BLANK state is absent and owner changes take effect directly.

## Test plan
- Reset, then `req` = 4'b0100 with one `frame_begin` → `grant` = 4'b0100 one cycle later. `switch_pulse` pulses once. `oled_colour` equals the slice-2 colour.
- `req` = 4'b0011 held for 20 frames, HOLD_FRAMES = 8 → grant alternates 0001, 0010, 0001 on frames 1, 9, 17.
- Owner drops `req` mid-frame → `grant` is unchanged until the next `frame_begin`, then goes to IDLE. `oled_colour` becomes `BG_COLOUR`.
- 6144 `sample_pixel` pulses with `pixel_index` 0..6143 → x/y end at 0/0 after wrap and `sync_err` = 0. Injecting `pixel_index` = 100 at count 99 sets `sync_err` = 1.
- `frame_begin` coincident with `sample_pixel` → x = 0, y = 0, and `frame_cnt` increments by exactly 1.
- With `OLED_SCHED_BLANK_EN` defined, owner switch 0→1 → one frame with `grant` = 0 and `oled_colour` = 0, then `grant` = 4'b0010.
